// File: rtl/leaf_stream_bridge.sv
// Buffered ap_vld/ap_ack stream bridge between the leaf interface and an HLS kernel, plus kernel start sequencing.
// Optional per-channel delivered-word counters are enabled with LEAF_STREAM_BRIDGE_STATS_EN.

module leaf_stream_fifo #(
    parameter int PAYLOAD_BITS    = 32,
    parameter int FIFO_DEPTH_BITS = 2
) (
    input  logic                       clk_user,
    input  logic                       reset_n,
    input  logic [PAYLOAD_BITS-1:0]    wr_data,
    input  logic                       wr_vld,
    output logic                       wr_ack,
    output logic [PAYLOAD_BITS-1:0]    rd_data,
    output logic                       rd_vld,
    input  logic                       rd_ack,
`ifdef LEAF_STREAM_BRIDGE_STATS_EN
    output logic [31:0]                xfer_count,
`endif
    output logic [FIFO_DEPTH_BITS:0]   fill
);
    localparam logic [FIFO_DEPTH_BITS:0] DEPTH = {1'b1, {FIFO_DEPTH_BITS{1'b0}}};

    logic [PAYLOAD_BITS-1:0]    mem [2**FIFO_DEPTH_BITS];
    logic [FIFO_DEPTH_BITS-1:0] wr_ptr;
    logic [FIFO_DEPTH_BITS-1:0] rd_ptr;
    logic                       push;
    logic                       pop;

    // Full is judged on registered fill only, so a same-cycle pop never frees a slot for the writer.
    assign wr_ack  = reset_n & wr_vld & (fill != DEPTH);
    assign rd_vld  = (fill != '0);
    assign rd_data = mem[rd_ptr];
    assign push    = wr_ack;
    assign pop     = rd_vld & rd_ack;

    always_ff @(posedge clk_user) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk_user) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + FIFO_DEPTH_BITS'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_DEPTH_BITS'(1);
            end
            case ({push, pop})
                2'b10:   fill <= fill + (FIFO_DEPTH_BITS+1)'(1);
                2'b01:   fill <= fill - (FIFO_DEPTH_BITS+1)'(1);
                default: fill <= fill;
            endcase
        end
    end

`ifdef LEAF_STREAM_BRIDGE_STATS_EN
    always_ff @(posedge clk_user) begin
        if (!reset_n) begin
            xfer_count <= '0;
        end else if (pop) begin
            xfer_count <= xfer_count + 32'd1;
        end
    end
`endif

endmodule

// state   | meaning
// ST_WAIT | counting down START_DELAY cycles after reset release, ap_start low
// ST_RUN  | kernel started, ap_start held high until the next reset
module leaf_stream_bridge #(
    parameter int PAYLOAD_BITS    = 32,
    parameter int NUM_IN_PORTS    = 2,
    parameter int NUM_OUT_PORTS   = 2,
    parameter int FIFO_DEPTH_BITS = 2,
    parameter int START_DELAY     = 4
) (
    input  logic                                       clk_user,
    input  logic                                       reset_n,
    input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]       dout_leaf_interface2user,
    input  logic [NUM_IN_PORTS-1:0]                    vld_interface2user,
    output logic [NUM_IN_PORTS-1:0]                    ack_user2interface,
    output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]       kernel_in_data,
    output logic [NUM_IN_PORTS-1:0]                    kernel_in_vld,
    input  logic [NUM_IN_PORTS-1:0]                    kernel_in_ack,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]      kernel_out_data,
    input  logic [NUM_OUT_PORTS-1:0]                   kernel_out_vld,
    output logic [NUM_OUT_PORTS-1:0]                   kernel_out_ack,
    output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]      din_leaf_user2interface,
    output logic [NUM_OUT_PORTS-1:0]                   vld_user2interface,
    input  logic [NUM_OUT_PORTS-1:0]                   ack_interface2user,
    output logic                                       ap_start,
`ifdef LEAF_STREAM_BRIDGE_STATS_EN
    output logic [(NUM_IN_PORTS+NUM_OUT_PORTS)*32-1:0] xfer_count,
`endif
    output logic [NUM_IN_PORTS*(FIFO_DEPTH_BITS+1)-1:0]  in_fill,
    output logic [NUM_OUT_PORTS*(FIFO_DEPTH_BITS+1)-1:0] out_fill
);
    localparam int FB = FIFO_DEPTH_BITS + 1;

    typedef enum logic {ST_WAIT, ST_RUN} start_state_t;

    start_state_t state;
    logic [7:0]   delay_cnt;

    for (genvar k = 0; k < NUM_IN_PORTS; k++) begin : g_in
        leaf_stream_fifo #(
            .PAYLOAD_BITS    (PAYLOAD_BITS),
            .FIFO_DEPTH_BITS (FIFO_DEPTH_BITS)
        ) u_fifo (
            .clk_user   (clk_user),
            .reset_n    (reset_n),
            .wr_data    (dout_leaf_interface2user[k*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .wr_vld     (vld_interface2user[k]),
            .wr_ack     (ack_user2interface[k]),
            .rd_data    (kernel_in_data[k*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .rd_vld     (kernel_in_vld[k]),
            .rd_ack     (kernel_in_ack[k]),
`ifdef LEAF_STREAM_BRIDGE_STATS_EN
            .xfer_count (xfer_count[k*32 +: 32]),
`endif
            .fill       (in_fill[k*FB +: FB])
        );
    end

    for (genvar k = 0; k < NUM_OUT_PORTS; k++) begin : g_out
        leaf_stream_fifo #(
            .PAYLOAD_BITS    (PAYLOAD_BITS),
            .FIFO_DEPTH_BITS (FIFO_DEPTH_BITS)
        ) u_fifo (
            .clk_user   (clk_user),
            .reset_n    (reset_n),
            .wr_data    (kernel_out_data[k*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .wr_vld     (kernel_out_vld[k]),
            .wr_ack     (kernel_out_ack[k]),
            .rd_data    (din_leaf_user2interface[k*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .rd_vld     (vld_user2interface[k]),
            .rd_ack     (ack_interface2user[k]),
`ifdef LEAF_STREAM_BRIDGE_STATS_EN
            .xfer_count (xfer_count[(NUM_IN_PORTS+k)*32 +: 32]),
`endif
            .fill       (out_fill[k*FB +: FB])
        );
    end

    // The terminal-count cycle itself moves to RUN, so START_DELAY = 0 starts on the first free-running edge.
    always_ff @(posedge clk_user) begin
        if (!reset_n) begin
            state     <= ST_WAIT;
            delay_cnt <= 8'(START_DELAY);
            ap_start  <= 1'b0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (delay_cnt == 8'd0) begin
                        state    <= ST_RUN;
                        ap_start <= 1'b1;
                    end else begin
                        delay_cnt <= delay_cnt - 8'd1;
                    end
                end
                ST_RUN: begin
                    ap_start <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_leaf_stream_bridge.sv
// Scoreboard bench for leaf_stream_bridge: directed vectors plus a randomised streaming run.
// Compile with LEAF_STREAM_BRIDGE_STATS_EN to also exercise the transfer counters.

module tb_leaf_stream_bridge;
    localparam int PB  = 32;
    localparam int NI  = 2;
    localparam int NO  = 2;
    localparam int DB  = 2;
    localparam int FB  = DB + 1;
    localparam int DEP = 4;
    localparam int NCH = NI + NO;
    localparam int NWORDS = 1000;

    logic                clk_user = 1'b0;
    logic                reset_n;
    logic [NI*PB-1:0]    dout_leaf_interface2user;
    logic [NI-1:0]       vld_interface2user;
    logic [NI-1:0]       ack_user2interface;
    logic [NI*PB-1:0]    kernel_in_data;
    logic [NI-1:0]       kernel_in_vld;
    logic [NI-1:0]       kernel_in_ack;
    logic [NO*PB-1:0]    kernel_out_data;
    logic [NO-1:0]       kernel_out_vld;
    logic [NO-1:0]       kernel_out_ack;
    logic [NO*PB-1:0]    din_leaf_user2interface;
    logic [NO-1:0]       vld_user2interface;
    logic [NO-1:0]       ack_interface2user;
    logic                ap_start;
    logic [NI*FB-1:0]    in_fill;
    logic [NO*FB-1:0]    out_fill;
`ifdef LEAF_STREAM_BRIDGE_STATS_EN
    logic [NCH*32-1:0]   xfer_count;
`endif

    int errors = 0;
    int checks = 0;
    logic [PB-1:0] exp_q [NCH][$];
    int  rcv_cnt [NCH];
    logic rst_seen = 1'b0;

    always #5 clk_user = ~clk_user;

    leaf_stream_bridge #(
        .PAYLOAD_BITS    (PB),
        .NUM_IN_PORTS    (NI),
        .NUM_OUT_PORTS   (NO),
        .FIFO_DEPTH_BITS (DB),
        .START_DELAY     (4)
    ) dut (
        .clk_user                 (clk_user),
        .reset_n                  (reset_n),
        .dout_leaf_interface2user (dout_leaf_interface2user),
        .vld_interface2user       (vld_interface2user),
        .ack_user2interface       (ack_user2interface),
        .kernel_in_data           (kernel_in_data),
        .kernel_in_vld            (kernel_in_vld),
        .kernel_in_ack            (kernel_in_ack),
        .kernel_out_data          (kernel_out_data),
        .kernel_out_vld           (kernel_out_vld),
        .kernel_out_ack           (kernel_out_ack),
        .din_leaf_user2interface  (din_leaf_user2interface),
        .vld_user2interface       (vld_user2interface),
        .ack_interface2user       (ack_interface2user),
        .ap_start                 (ap_start),
`ifdef LEAF_STREAM_BRIDGE_STATS_EN
        .xfer_count               (xfer_count),
`endif
        .in_fill                  (in_fill),
        .out_fill                 (out_fill)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk_user) rst_seen <= !reset_n;

    // Monitor: queue depth per channel is the reference occupancy for fill, ack and vld.
    always @(negedge clk_user) begin
        if (!reset_n) begin
            for (int c = 0; c < NCH; c++) exp_q[c].delete();
            chk("rst_ack_in", ack_user2interface, 0);
            chk("rst_ack_out", kernel_out_ack, 0);
            if (rst_seen) begin
                chk("rst_vld_in", kernel_in_vld, 0);
                chk("rst_vld_out", vld_user2interface, 0);
                chk("rst_fill", {in_fill, out_fill}, 0);
                chk("rst_ap_start", ap_start, 0);
            end
        end else begin
            for (int k = 0; k < NI; k++) begin
                chk("in_fill", in_fill[k*FB +: FB], exp_q[k].size());
                chk("in_ack", ack_user2interface[k],
                    vld_interface2user[k] && (exp_q[k].size() < DEP));
                chk("in_vld", kernel_in_vld[k], exp_q[k].size() != 0);
                if (kernel_in_vld[k] && kernel_in_ack[k] && exp_q[k].size() != 0) begin
                    chk("in_data", kernel_in_data[k*PB +: PB], exp_q[k].pop_front());
                    rcv_cnt[k]++;
                end
                if (vld_interface2user[k] && ack_user2interface[k])
                    exp_q[k].push_back(dout_leaf_interface2user[k*PB +: PB]);
            end
            for (int j = 0; j < NO; j++) begin
                chk("out_fill", out_fill[j*FB +: FB], exp_q[NI+j].size());
                chk("out_ack", kernel_out_ack[j],
                    kernel_out_vld[j] && (exp_q[NI+j].size() < DEP));
                chk("out_vld", vld_user2interface[j], exp_q[NI+j].size() != 0);
                if (vld_user2interface[j] && ack_interface2user[j] && exp_q[NI+j].size() != 0) begin
                    chk("out_data", din_leaf_user2interface[j*PB +: PB], exp_q[NI+j].pop_front());
                    rcv_cnt[NI+j]++;
                end
                if (kernel_out_vld[j] && kernel_out_ack[j])
                    exp_q[NI+j].push_back(kernel_out_data[j*PB +: PB]);
            end
        end
    end

    initial begin
        int sent_in [NI];
        int sent_out [NO];
        int base [NCH];
        logic [NI-1:0] acc_in;
        logic [NO-1:0] acc_out;
        bit done;

        for (int c = 0; c < NCH; c++) rcv_cnt[c] = 0;
        reset_n = 1'b0;
        dout_leaf_interface2user = {PB'(32'h1111_1111), PB'(32'h2222_2222)};
        vld_interface2user = 2'b11;
        kernel_in_ack = '0;
        kernel_out_data = '0;
        kernel_out_vld = '0;
        ack_interface2user = '0;

        // Reset with input offered, then start delay
        repeat (4) @(posedge clk_user);
        @(negedge clk_user);
        chk("reset_ack", ack_user2interface, 0);
        chk("reset_kvld", kernel_in_vld, 0);
        chk("reset_start", ap_start, 0);
        @(posedge clk_user); #1;
        reset_n = 1'b1;
        vld_interface2user = '0;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk_user); #1;
            chk("start_delay", ap_start, (i == 5));
        end

        // Single word on input channel 1
        @(posedge clk_user); #1;
        dout_leaf_interface2user[PB +: PB] = 32'hDEAD_BEEF;
        vld_interface2user[1] = 1'b1;
        @(negedge clk_user);
        chk("single_ack", ack_user2interface[1], 1);
        @(posedge clk_user); #1;
        vld_interface2user[1] = 1'b0;
        @(negedge clk_user);
        chk("single_vld", kernel_in_vld[1], 1);
        chk("single_data", kernel_in_data[PB +: PB], 32'hDEAD_BEEF);
        chk("single_fill", in_fill[FB +: FB], 1);
        repeat (2) @(posedge clk_user);
        @(negedge clk_user);
        chk("single_hold", in_fill[FB +: FB], 1);
        @(posedge clk_user); #1;
        kernel_in_ack[1] = 1'b1;
        @(posedge clk_user); #1;
        kernel_in_ack[1] = 1'b0;
        @(negedge clk_user);
        chk("single_drained", in_fill[FB +: FB], 0);

        // Fill channel 0 to full, fifth word held
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk_user); #1;
            dout_leaf_interface2user[0 +: PB] = PB'(i);
            vld_interface2user[0] = 1'b1;
            @(negedge clk_user);
            chk("fill_ack", ack_user2interface[0], (i <= 4));
        end
        chk("full_level", in_fill[0 +: FB], 4);
        @(posedge clk_user); #1;
        kernel_in_ack[0] = 1'b1;
        @(negedge clk_user);
        chk("full_pop_ack", ack_user2interface[0], 0);
        chk("full_pop_head", kernel_in_data[0 +: PB], 1);
        @(posedge clk_user); #1;
        @(negedge clk_user);
        chk("retry_ack", ack_user2interface[0], 1);
        chk("retry_fill", in_fill[0 +: FB], 3);
        @(posedge clk_user); #1;
        vld_interface2user[0] = 1'b0;
        repeat (4) @(posedge clk_user);
        #1;
        kernel_in_ack[0] = 1'b0;
        @(negedge clk_user);
        chk("drain_empty", in_fill[0 +: FB], 0);
        chk("drain_count", rcv_cnt[0], 5);

        // Random streaming on every channel
        for (int c = 0; c < NCH; c++) base[c] = rcv_cnt[c];
        for (int k = 0; k < NI; k++) sent_in[k] = 0;
        for (int j = 0; j < NO; j++) sent_out[j] = 0;
        acc_in = '0;
        acc_out = '0;
        done = 1'b0;
        for (int cyc = 0; cyc < 30000 && !done; cyc++) begin
            @(posedge clk_user); #1;
            for (int k = 0; k < NI; k++) begin
                if (acc_in[k]) begin
                    sent_in[k]++;
                    vld_interface2user[k] = 1'b0;
                end
                if (!vld_interface2user[k] && sent_in[k] < NWORDS && $urandom_range(3) != 0) begin
                    dout_leaf_interface2user[k*PB +: PB] = PB'($urandom);
                    vld_interface2user[k] = 1'b1;
                end
            end
            for (int j = 0; j < NO; j++) begin
                if (acc_out[j]) begin
                    sent_out[j]++;
                    kernel_out_vld[j] = 1'b0;
                end
                if (!kernel_out_vld[j] && sent_out[j] < NWORDS && $urandom_range(3) != 0) begin
                    kernel_out_data[j*PB +: PB] = PB'($urandom);
                    kernel_out_vld[j] = 1'b1;
                end
            end
            kernel_in_ack = NI'($urandom);
            ack_interface2user = NO'($urandom);
            @(negedge clk_user);
            acc_in = vld_interface2user & ack_user2interface;
            acc_out = kernel_out_vld & kernel_out_ack;
            done = 1'b1;
            for (int k = 0; k < NI; k++)
                if (sent_in[k] < NWORDS || vld_interface2user[k] || exp_q[k].size() != 0) done = 1'b0;
            for (int j = 0; j < NO; j++)
                if (sent_out[j] < NWORDS || kernel_out_vld[j] || exp_q[NI+j].size() != 0) done = 1'b0;
        end
        chk("stream_timeout", done, 1);
        for (int c = 0; c < NCH; c++) chk("stream_delivered", rcv_cnt[c] - base[c], NWORDS);
        @(posedge clk_user); #1;
        kernel_in_ack = '0;
        ack_interface2user = '0;

        // Reset with words offered on both sides
        reset_n = 1'b0;
        vld_interface2user = 2'b11;
        kernel_out_vld = 2'b11;
        repeat (2) @(posedge clk_user);
        #1;
        vld_interface2user = '0;
        kernel_out_vld = '0;
        reset_n = 1'b1;
        @(negedge clk_user);
        chk("post_reset_fill", {in_fill, out_fill}, 0);

`ifdef LEAF_STREAM_BRIDGE_STATS_EN
        ack_interface2user[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_user); #1;
            kernel_out_data[0 +: PB] = PB'(32'hA000 + i);
            kernel_out_vld[0] = 1'b1;
        end
        @(posedge clk_user); #1;
        kernel_out_vld[0] = 1'b0;
        repeat (3) @(posedge clk_user);
        @(negedge clk_user);
        chk("stats_out0", xfer_count[NI*32 +: 32], 10);
        chk("stats_in0", xfer_count[0 +: 32], 0);
        @(posedge clk_user); #1;
        ack_interface2user = '0;
        reset_n = 1'b0;
        @(posedge clk_user); #1;
        reset_n = 1'b1;
        @(negedge clk_user);
        chk("stats_cleared", xfer_count[NI*32 +: 32], 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
